neuron_writeback: RTL and testbench
===================================

NEURON_WRITEBACK -- requirements
Module: neuron_writeback

Interface
REQ-001 Parameter ACC_W, default 24, width of the signed neuron accumulator.
REQ-002 Parameter FIFO_DEPTH, default 4, number of result entries buffered ahead of the BRAM write port.
REQ-003 clk  input  1  clock; all logic is rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 psum  input  16  signed Q8.8 partial sum from the PE adder tree.
REQ-006 add_done  input  1  single-cycle strobe; psum is valid this cycle.
REQ-007 neuron_done  input  1  single-cycle strobe; the current neuron is complete.
REQ-008 out_addr  input  16  BRAM address for the current neuron; sampled on neuron_done.
REQ-009 relu_en  input  1  apply ReLU to the finalized result; sampled on neuron_done.
REQ-010 bram_ack  input  1  BRAM write port has accepted the presented write.
REQ-011 bram_wr_en  output  1  write request; held until acknowledged.
REQ-012 bram_addr  output  16  write address.
REQ-013 bram_wdata  output  16  write data, signed Q8.8.
REQ-014 fifo_full  output  1  result FIFO holds FIFO_DEPTH entries.
REQ-015 busy  output  1  accumulator is non-zero, FIFO is non-empty, or bram_wr_en is high.
REQ-016 ovf_err  output  1  sticky flag; a result was dropped.

Function
REQ-017 On add_done, acc SHALL become acc + sign-extended psum at the next edge (1-cycle latency); no wrap check is made at ACC_W.
REQ-018 On neuron_done, the result SHALL be formed from acc plus psum when add_done is also high, otherwise from acc alone.
REQ-019 The result SHALL saturate to 16-bit signed: above 0x7FFF gives 0x7FFF; below -0x8000 gives 0x8000.
REQ-020 When relu_en is high, the result SHALL be forced to 0x0000 if negative, after saturation.
REQ-021 The entry {out_addr, result} SHALL be pushed into the FIFO at the next edge.
REQ-022 On that same edge, acc SHALL clear to 0, including when add_done was simultaneous.
REQ-023 If neuron_done arrives while the FIFO is full and no pop occurs that cycle, the entry SHALL be dropped, ovf_err set, and acc still cleared.
REQ-024 A push and a pop in the same cycle on a full FIFO SHALL both succeed; the count is unchanged.
REQ-025 The write side SHALL be an FSM with two states:
  - W_IDLE: when the FIFO is non-empty, go to W_REQ and drive bram_wr_en=1 with the head entry at the next edge.
  - W_REQ: hold bram_wr_en, bram_addr and bram_wdata stable until bram_ack is sampled high; on ack, pop.
  - After ack, if another entry remains: stay in W_REQ and present the next entry the following cycle (back-to-back writes allowed).
  - After ack, if the FIFO is empty: go to W_IDLE with bram_wr_en=0.
REQ-026 Writes SHALL reach BRAM in neuron_done order.
REQ-027 Latency from neuron_done to the first bram_wr_en, with the FIFO empty and the FSM in W_IDLE, SHALL be 2 cycles.
REQ-028 bram_ack sampled while bram_wr_en is low SHALL be ignored.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are derived from an occupancy count.

Reset
REQ-030 When rst=0 at an edge, the following SHALL reset: acc=0, FIFO count and pointers=0, write FSM=W_IDLE, bram_wr_en=0, bram_addr=0, bram_wdata=0, ovf_err=0.
REQ-031 Reset mid-write SHALL abandon the pending entry and all queued entries; no write is issued after reset until a new neuron_done.
REQ-032 While rst=0, strobes SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold:
  - the Q8.8 saturation limits (16'h7FFF, 16'h8000);
  - the ACC_W and FIFO_DEPTH defaults;
  - the write-FSM state encodings W_IDLE=1'b0 and W_REQ=1'b1.
REQ-034 The FIFO SHALL be one sub-module, wb_result_fifo: 32-bit {addr, data} entries, with push/pop/full/empty/count ports.

Verification
REQ-035 Accumulate: psum=0x0100 with add_done x4, then neuron_done with out_addr=0x0010, relu_en=0, ack tied high -> one write, addr 0x0010, data 0x0400, 2 cycles after neuron_done.
REQ-036 Saturation and ReLU:
  - 0x7000 x2 -> 0x7FFF.
  - 0x9000 x2 -> 0x8000.
  - 0x9000 with relu_en=1 -> 0x0000.
REQ-037 Backpressure: bram_ack=0, 5 neuron_done with addrs 0x20..0x24 -> fifo_full=1 after the 4th, ovf_err=1, 0x24 dropped; release ack -> writes 0x20..0x23 in order, back-to-back.
REQ-038 Simultaneous strobes: acc=0x0200, add_done+neuron_done with psum=0x0100 -> data 0x0300; the next neuron starts from acc=0.
REQ-039 Reset mid-operation: 2 entries queued, bram_wr_en high, rst=0 for 1 cycle -> bram_wr_en=0, busy=0, ovf_err=0, no further writes.
REQ-040 Push during pop on a full FIFO with ack=1 -> no drop, ovf_err stays 0, count stays 4.

Source files
------------

// File: rtl/neuron_writeback_pkg.sv
// Shared definitions for the neuron write-back path: Q8.8 saturation
// limits, default sizing, write-FSM state encodings and the FIFO entry layout.
package neuron_writeback_pkg;

    localparam int ACC_W_DEFAULT      = 24;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Q8.8 signed limits used when narrowing the accumulator to 16 bits
    localparam logic [15:0] Q88_MAX = 16'h7FFF;
    localparam logic [15:0] Q88_MIN = 16'h8000;

    localparam int ENTRY_W = 32;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } w_state_t;

    // One buffered BRAM write: address in the upper half, Q8.8 data below
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Result FIFO between the neuron finaliser and the BRAM write FSM.
// Pointers wrap modulo DEPTH (no power-of-two assumption); full/empty come
// from the occupancy count. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. next_data exposes the entry behind the head
// so the write FSM can issue back-to-back writes from registered outputs.
module wb_result_fifo
    import neuron_writeback_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic [ENTRY_W-1:0] next_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head_data = mem[rd_ptr];
    assign next_data = mem[ptr_inc(rd_ptr)];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/neuron_writeback.sv
// Neuron write-back: accumulates Q8.8 partial sums, finalises each neuron
// with saturation and optional ReLU, queues {addr, data} results and drains
// them to a BRAM write port with a req/ack handshake.
//
// Write FSM states
//   state  | meaning
//   W_IDLE | nothing presented, bram_wr_en low, waiting for a queued entry
//   W_REQ  | head entry presented on bram_addr/bram_wdata, waiting for ack
module neuron_writeback
    import neuron_writeback_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] psum,
    input  logic        add_done,
    input  logic        neuron_done,
    input  logic [15:0] out_addr,
    input  logic        relu_en,
    input  logic        bram_ack,
    output logic        bram_wr_en,
    output logic [15:0] bram_addr,
    output logic [15:0] bram_wdata,
    output logic        fifo_full,
    output logic        busy,
    output logic        ovf_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'($signed(Q88_MAX));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'($signed(Q88_MIN));

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] sum;
    logic        [15:0]      result;
    wb_entry_t               entry;

    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_next;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    w_state_t w_state;
    logic     pop;
    logic     push_ok;
    logic     drop;
    logic     more_left;

    assign psum_ext = ACC_W'($signed(psum));
    // The finishing psum is folded in when both strobes coincide
    assign sum      = acc + (add_done ? psum_ext : '0);

    // Narrow to Q8.8 with saturation, then optional ReLU on the narrowed value
    always_comb begin
        result = sum[15:0];
        if (sum > SAT_HI)      result = Q88_MAX;
        else if (sum < SAT_LO) result = Q88_MIN;
        if (relu_en && result[15]) result = '0;
    end

    assign entry.addr = out_addr;
    assign entry.data = result;

    // Only a presented write can be acknowledged; stray acks are ignored
    assign pop       = (w_state == W_REQ) && bram_ack;
    assign push_ok   = neuron_done && (!fifo_full || pop);
    assign drop      = neuron_done && fifo_full && !pop;
    // After this ack, is there anything to present next cycle?
    assign more_left = (fifo_count > CNT_W'(1)) || push_ok;

    // Accumulator: cleared on every neuron boundary, even with a coincident add
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (neuron_done) begin
            acc <= '0;
        end else if (add_done) begin
            acc <= acc + psum_ext;
        end
    end

    // Sticky record that a finished neuron could not be queued
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (drop) begin
            ovf_err <= 1'b1;
        end
    end

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (neuron_done),
        .push_data (entry),
        .pop       (pop),
        .head_data (fifo_head),
        .next_data (fifo_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Write FSM with registered BRAM outputs. On ack the follow-on entry is
    // the one behind the head, or the entry being pushed this very cycle if
    // the head was the last one stored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state    <= W_IDLE;
            bram_wr_en <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (!fifo_empty) begin
                        w_state    <= W_REQ;
                        bram_wr_en <= 1'b1;
                        bram_addr  <= fifo_head[31:16];
                        bram_wdata <= fifo_head[15:0];
                    end
                end
                W_REQ: begin
                    if (bram_ack) begin
                        if (more_left) begin
                            if (fifo_count > CNT_W'(1)) begin
                                bram_addr  <= fifo_next[31:16];
                                bram_wdata <= fifo_next[15:0];
                            end else begin
                                bram_addr  <= entry.addr;
                                bram_wdata <= entry.data;
                            end
                        end else begin
                            w_state    <= W_IDLE;
                            bram_wr_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    w_state    <= W_IDLE;
                    bram_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (acc != '0) || !fifo_empty || bram_wr_en;

endmodule

// File: tb/tb_neuron_writeback.sv
// Directed bench for neuron_writeback: accumulation, saturation/ReLU,
// backpressure with overflow, coincident strobes, reset mid-write and
// push-during-pop on a full FIFO. Accepted writes are logged per clock.
module tb_neuron_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] psum;
    logic        add_done;
    logic        neuron_done;
    logic [15:0] out_addr;
    logic        relu_en;
    logic        bram_ack;
    logic        bram_wr_en;
    logic [15:0] bram_addr;
    logic [15:0] bram_wdata;
    logic        fifo_full;
    logic        busy;
    logic        ovf_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] wq[$];
    int          wcyc[$];

    always #5 clk = ~clk;

    neuron_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .psum        (psum),
        .add_done    (add_done),
        .neuron_done (neuron_done),
        .out_addr    (out_addr),
        .relu_en     (relu_en),
        .bram_ack    (bram_ack),
        .bram_wr_en  (bram_wr_en),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .fifo_full   (fifo_full),
        .busy        (busy),
        .ovf_err     (ovf_err)
    );

    // Log every write the BRAM accepts, with the clock index it happened on
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && bram_wr_en && bram_ack) begin
            wq.push_back({bram_addr, bram_wdata});
            wcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic accum(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            psum     = p;
            add_done = 1'b1;
            step();
        end
        add_done = 1'b0;
    endtask

    task automatic finish_neuron(input logic [15:0] addr, input logic relu,
                                 input logic with_add, input logic [15:0] p);
        neuron_done = 1'b1;
        out_addr    = addr;
        relu_en     = relu;
        add_done    = with_add;
        psum        = p;
        step();
        neuron_done = 1'b0;
        add_done    = 1'b0;
        relu_en     = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [15:0] addr,
                                input logic [15:0] data, output int wc);
        int n;
        n  = 0;
        wc = -1;
        while (wq.size() == 0 && n < 20) begin
            step();
            n++;
        end
        if (wq.size() == 0) begin
            check({tag, "_timeout"}, 32'(wq.size()), 32'd1);
        end else begin
            wc = wcyc.pop_front();
            check(tag, wq.pop_front(), {addr, data});
        end
    endtask

    initial begin
        int c;
        int prev;

        rst         = 1'b0;
        psum        = '0;
        add_done    = 1'b0;
        neuron_done = 1'b0;
        out_addr    = '0;
        relu_en     = 1'b0;
        bram_ack    = 1'b0;
        steps(3);
        check("rst_wr_en", 32'(bram_wr_en), 32'd0);
        check("rst_addr",  32'(bram_addr),  32'd0);
        check("rst_wdata", 32'(bram_wdata), 32'd0);
        check("rst_full",  32'(fifo_full),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_ovf",   32'(ovf_err),    32'd0);
        rst = 1'b1;
        step();

        // Accumulate four 1.0 values, expect 4.0 two cycles after neuron_done
        bram_ack = 1'b1;
        accum(16'h0100, 4);
        finish_neuron(16'h0010, 1'b0, 1'b0, 16'h0000);
        check("acc_lat1_wr_en", 32'(bram_wr_en), 32'd0);
        step();
        check("acc_lat2_wr_en", 32'(bram_wr_en), 32'd1);
        check("acc_addr",       32'(bram_addr),  32'h0010);
        check("acc_wdata",      32'(bram_wdata), 32'h0400);
        expect_write("acc_wr", 16'h0010, 16'h0400, c);
        check("acc_idle_wr_en", 32'(bram_wr_en), 32'd0);
        steps(3);
        check("acc_single", 32'(wq.size()), 32'd0);

        // Saturation and ReLU
        accum(16'h7000, 2);
        finish_neuron(16'h0011, 1'b0, 1'b0, 16'h0000);
        expect_write("sat_pos", 16'h0011, 16'h7FFF, c);
        accum(16'h9000, 2);
        finish_neuron(16'h0012, 1'b0, 1'b0, 16'h0000);
        expect_write("sat_neg", 16'h0012, 16'h8000, c);
        accum(16'h9000, 1);
        finish_neuron(16'h0013, 1'b1, 1'b0, 16'h0000);
        expect_write("relu_neg", 16'h0013, 16'h0000, c);
        accum(16'h0100, 1);
        check("busy_acc", 32'(busy), 32'd1);
        finish_neuron(16'h0014, 1'b1, 1'b0, 16'h0000);
        expect_write("relu_pos", 16'h0014, 16'h0100, c);
        accum(16'h7FFF, 1);
        finish_neuron(16'h0015, 1'b0, 1'b0, 16'h0000);
        expect_write("sat_edge", 16'h0015, 16'h7FFF, c);

        // Backpressure: fifth entry is dropped, then four back-to-back writes
        bram_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            finish_neuron(16'h0020 + 16'(i), 1'b0, 1'b1, 16'h0100 + 16'(i));
            if (i == 3) begin
                check("bp_full4", 32'(fifo_full), 32'd1);
                check("bp_ovf4",  32'(ovf_err),   32'd0);
            end
        end
        check("bp_ovf5",  32'(ovf_err),   32'd1);
        check("bp_full5", 32'(fifo_full), 32'd1);
        bram_ack = 1'b1;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            expect_write($sformatf("bp_wr%0d", i), 16'h0020 + 16'(i), 16'h0100 + 16'(i), c);
            if (i > 0) check($sformatf("bp_b2b%0d", i), 32'(c - prev), 32'd1);
            prev = c;
        end
        steps(3);
        check("bp_dropped",  32'(wq.size()),  32'd0);
        check("bp_wr_en",    32'(bram_wr_en), 32'd0);
        check("bp_ovf_stky", 32'(ovf_err),    32'd1);

        // Coincident strobes, then next neuron starts from zero
        accum(16'h0200, 1);
        finish_neuron(16'h0040, 1'b0, 1'b1, 16'h0100);
        finish_neuron(16'h0041, 1'b0, 1'b0, 16'h0000);
        accum(16'h0080, 1);
        finish_neuron(16'h0042, 1'b0, 1'b0, 16'h0000);
        expect_write("sim_wr",   16'h0040, 16'h0300, c);
        expect_write("sim_zero", 16'h0041, 16'h0000, c);
        expect_write("sim_next", 16'h0042, 16'h0080, c);

        // Reset while a write is pending with another entry queued
        bram_ack = 1'b0;
        finish_neuron(16'h0050, 1'b0, 1'b1, 16'h0011);
        finish_neuron(16'h0051, 1'b0, 1'b1, 16'h0022);
        step();
        check("rm_pre_wr_en", 32'(bram_wr_en), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rm_wr_en", 32'(bram_wr_en), 32'd0);
        check("rm_busy",  32'(busy),       32'd0);
        check("rm_ovf",   32'(ovf_err),    32'd0);
        check("rm_full",  32'(fifo_full),  32'd0);
        bram_ack = 1'b1;
        steps(10);
        check("rm_no_wr", 32'(wq.size()), 32'd0);

        // Push and pop in the same cycle on a full FIFO
        bram_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            finish_neuron(16'h0030 + 16'(i), 1'b0, 1'b1, 16'h0010 + 16'(i));
        check("pp_full_pre", 32'(fifo_full), 32'd1);
        bram_ack = 1'b1;
        finish_neuron(16'h0034, 1'b0, 1'b1, 16'h0014);
        check("pp_full", 32'(fifo_full), 32'd1);
        check("pp_ovf",  32'(ovf_err),   32'd0);
        for (int i = 0; i < 5; i++)
            expect_write($sformatf("pp_wr%0d", i), 16'h0030 + 16'(i), 16'h0010 + 16'(i), c);
        steps(3);
        check("pp_done", 32'(bram_wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
